// File: rtl/team_06_pwm_dac_if.sv
// rtl/team_06_pwm_dac_if.sv - sample/control/status bundle between the tremolo stage and the PWM DAC
interface team_06_pwm_dac_if;
    logic [7:0] sample_in;
    logic       sample_strobe;
    logic       en;
    logic       mute;
    logic       clr_flags;
    logic       pwm_out;
    logic       underrun;
    logic       overrun;

    modport master (
        output sample_in, sample_strobe, en, mute, clr_flags,
        input  pwm_out, underrun, overrun
    );

    modport slave (
        input  sample_in, sample_strobe, en, mute, clr_flags,
        output pwm_out, underrun, overrun
    );
endinterface

// File: rtl/team_06_pwm_dac.sv
// rtl/team_06_pwm_dac.sv - double-buffered 8-bit PWM DAC, 255-clock period; TEAM_06_PWM_SOFTMUTE_EN ramps mute
module team_06_pwm_dac #(
    parameter logic [7:0] MUTE_LEVEL = 8'd128
) (
    input  logic                      clk,
    input  logic                      rst,
    team_06_pwm_dac_if.slave          bus
);

    localparam logic [7:0] CNT_LAST = 8'd254;

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] active_q, active_d;
    logic [7:0] pending_q, pending_d;
    logic       pending_valid_q, pending_valid_d;
    logic       pwm_q, pwm_d;
    logic       underrun_q, underrun_d;
    logic       overrun_q, overrun_d;

    logic boundary;
    logic underrun_set;
    logic overrun_set;

    assign boundary = bus.en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d           = 8'd0;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        underrun_set    = 1'b0;
        overrun_set     = 1'b0;

        if (bus.en) begin
            cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
        end

        // Strobes landing in the boundary cycle bypass the buffer entirely.
        if (bus.sample_strobe && !boundary) begin
            pending_d       = bus.sample_in;
            pending_valid_d = 1'b1;
            overrun_set     = pending_valid_q;
        end

        if (boundary) begin
            if (bus.mute) begin
`ifdef TEAM_06_PWM_SOFTMUTE_EN
                if (active_q > MUTE_LEVEL) begin
                    active_d = active_q - 8'd1;
                end else if (active_q < MUTE_LEVEL) begin
                    active_d = active_q + 8'd1;
                end
                pending_valid_d = 1'b0;
`else
                active_d = MUTE_LEVEL;
`endif
            end else if (bus.sample_strobe) begin
                active_d        = bus.sample_in;
                pending_valid_d = 1'b0;
            end else if (pending_valid_q) begin
                active_d        = pending_q;
                pending_valid_d = 1'b0;
            end else begin
                underrun_set = 1'b1;
            end
        end

        pwm_d      = bus.en && (cnt_q < active_q);
        underrun_d = (underrun_q && !bus.clr_flags) || underrun_set;
        overrun_d  = (overrun_q && !bus.clr_flags) || overrun_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= 8'd0;
            active_q        <= MUTE_LEVEL;
            pending_q       <= MUTE_LEVEL;
            pending_valid_q <= 1'b0;
            pwm_q           <= 1'b0;
            underrun_q      <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            pwm_q           <= pwm_d;
            underrun_q      <= underrun_d;
            overrun_q       <= overrun_d;
        end
    end

    assign bus.pwm_out  = pwm_q;
    assign bus.underrun = underrun_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_team_06_pwm_dac.sv
// tb/tb_team_06_pwm_dac.sv - directed self-checking bench for team_06_pwm_dac
module tb_team_06_pwm_dac;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    team_06_pwm_dac_if bus ();

    team_06_pwm_dac #(.MUTE_LEVEL(8'd128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One aligned 255-clock period; slot k drives the cycle in which cnt==k.
    task automatic count_period(input int s1, input logic [7:0] v1,
                                input int s2, input logic [7:0] v2,
                                input int c1, input int c2,
                                output int highs);
        highs = 0;
        for (int k = 0; k < 255; k++) begin
            bus.sample_strobe = (k == s1) || (k == s2);
            bus.sample_in     = (k == s2) ? v2 : v1;
            bus.clr_flags     = (k == c1) || (k == c2);
            step();
            if (bus.pwm_out === 1'b1) highs++;
        end
        bus.sample_strobe = 1'b0;
        bus.clr_flags     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.mute = 1'b0;
        bus.sample_strobe = 1'b0;
        bus.sample_in = 8'd0;
        bus.clr_flags = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        total++;
        if (bus.pwm_out !== 1'b0) begin
            bad++; $display("FAIL reset_pwm got=%b want=0", bus.pwm_out);
        end
        total++;
        if (bus.underrun !== 1'b0) begin
            bad++; $display("FAIL reset_underrun got=%b want=0", bus.underrun);
        end
        total++;
        if (bus.overrun !== 1'b0) begin
            bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun);
        end
    endtask

    task automatic test_idle_underrun();
        int h;
        bus.en = 1'b1;
        count_period(-1, 8'd0, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 128) begin
            bad++; $display("FAIL idle_highs got=%0d want=128", h);
        end
        total++;
        if (bus.underrun !== 1'b1) begin
            bad++; $display("FAIL idle_underrun got=%b want=1", bus.underrun);
        end
    endtask

    task automatic test_capture();
        int h;
        count_period(100, 8'h40, -1, 8'd0, 50, -1, h);
        total++;
        if (h !== 128) begin
            bad++; $display("FAIL capture_hold_highs got=%0d want=128", h);
        end
        total++;
        if (bus.underrun !== 1'b0) begin
            bad++; $display("FAIL capture_no_underrun got=%b want=0", bus.underrun);
        end
        total++;
        if (bus.overrun !== 1'b0) begin
            bad++; $display("FAIL capture_no_overrun got=%b want=0", bus.overrun);
        end
        count_period(-1, 8'd0, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 64) begin
            bad++; $display("FAIL capture_highs got=%0d want=64", h);
        end
        total++;
        if (bus.underrun !== 1'b1) begin
            bad++; $display("FAIL capture_then_underrun got=%b want=1", bus.underrun);
        end
    endtask

    task automatic test_extremes();
        int h;
        count_period(10, 8'h00, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 64) begin
            bad++; $display("FAIL repeat_highs got=%0d want=64", h);
        end
        count_period(10, 8'hFF, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 0) begin
            bad++; $display("FAIL zero_duty_highs got=%0d want=0", h);
        end
    endtask

    task automatic test_overrun();
        int h;
        count_period(20, 8'h10, 40, 8'h20, 0, -1, h);
        total++;
        if (h !== 255) begin
            bad++; $display("FAIL full_duty_highs got=%0d want=255", h);
        end
        total++;
        if (bus.overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set got=%b want=1", bus.overrun);
        end
        count_period(20, 8'h30, 40, 8'h50, 5, 40, h);
        total++;
        if (h !== 32) begin
            bad++; $display("FAIL overrun_highs got=%0d want=32", h);
        end
        total++;
        if (bus.overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set_beats_clr got=%b want=1", bus.overrun);
        end
        total++;
        if (bus.underrun !== 1'b0) begin
            bad++; $display("FAIL overrun_no_underrun got=%b want=0", bus.underrun);
        end
    endtask

    task automatic test_bypass();
        int h;
        count_period(254, 8'h80, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 80) begin
            bad++; $display("FAIL latest_wins_highs got=%0d want=80", h);
        end
        total++;
        if (bus.underrun !== 1'b0) begin
            bad++; $display("FAIL bypass_no_underrun got=%b want=0", bus.underrun);
        end
        count_period(10, 8'hC8, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 128) begin
            bad++; $display("FAIL bypass_highs got=%0d want=128", h);
        end
    endtask

    task automatic test_mute();
        int h;
        bus.mute = 1'b1;
        count_period(-1, 8'd0, -1, 8'd0, 5, -1, h);
        total++;
        if (h !== 200) begin
            bad++; $display("FAIL mute_delayed_highs got=%0d want=200", h);
        end
        total++;
        if (bus.underrun !== 1'b0) begin
            bad++; $display("FAIL mute_no_underrun got=%b want=0", bus.underrun);
        end
        count_period(-1, 8'd0, -1, 8'd0, -1, -1, h);
`ifdef TEAM_06_PWM_SOFTMUTE_EN
        total++;
        if (h !== 199) begin
            bad++; $display("FAIL softmute_first_highs got=%0d want=199", h);
        end
        count_period(-1, 8'd0, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 198) begin
            bad++; $display("FAIL softmute_second_highs got=%0d want=198", h);
        end
        for (int p = 3; p <= 72; p++) count_period(-1, 8'd0, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 128) begin
            bad++; $display("FAIL softmute_final_highs got=%0d want=128", h);
        end
`else
        total++;
        if (h !== 128) begin
            bad++; $display("FAIL mute_highs got=%0d want=128", h);
        end
`endif
        bus.mute = 1'b0;
    endtask

    task automatic test_enable();
        int h;
        int lows;
        repeat (30) step();
        total++;
        if (bus.pwm_out !== 1'b1) begin
            bad++; $display("FAIL en_mid_pwm got=%b want=1", bus.pwm_out);
        end
        bus.en = 1'b0;
        step();
        total++;
        if (bus.pwm_out !== 1'b0) begin
            bad++; $display("FAIL en_fall_pwm got=%b want=0", bus.pwm_out);
        end
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.pwm_out === 1'b0) lows++;
        end
        total++;
        if (lows !== 10) begin
            bad++; $display("FAIL en_off_lows got=%0d want=10", lows);
        end
        bus.en = 1'b1;
        count_period(-1, 8'd0, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 128) begin
            bad++; $display("FAIL en_restart_highs got=%0d want=128", h);
        end
    endtask

    task automatic test_reset_mid();
        int h;
        repeat (50) step();
        total++;
        if (bus.pwm_out !== 1'b1) begin
            bad++; $display("FAIL pre_reset_pwm got=%b want=1", bus.pwm_out);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (bus.pwm_out !== 1'b0) begin
            bad++; $display("FAIL midreset_pwm got=%b want=0", bus.pwm_out);
        end
        total++;
        if (bus.underrun !== 1'b0) begin
            bad++; $display("FAIL midreset_underrun got=%b want=0", bus.underrun);
        end
        count_period(-1, 8'd0, -1, 8'd0, -1, -1, h);
        total++;
        if (h !== 128) begin
            bad++; $display("FAIL midreset_highs got=%0d want=128", h);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_idle_underrun();
        test_capture();
        test_extremes();
        test_overrun();
        test_bypass();
        test_mute();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
